// File: rtl/press_classifier_pkg.sv
// Shared types and event codes for the press classifier.
package press_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED1 = 2'd1,
    ARMED2 = 2'd2
  } state_t;

  typedef logic [1:0] ev_code_t;

  localparam ev_code_t EV_NONE   = 2'b00;
  localparam ev_code_t EV_SINGLE = 2'b01;
  localparam ev_code_t EV_DOUBLE = 2'b10;
  localparam ev_code_t EV_TRIPLE = 2'b11;

endpackage

// File: rtl/press_classifier_if.sv
// Classified-event valid/ack handshake between the classifier and its consumer.
interface press_classifier_if;
  import press_pkg::*;

  logic     ev_valid;
  ev_code_t ev_code;
  logic     ev_ack;

  modport master (output ev_valid, output ev_code, input ev_ack);
  modport slave  (input ev_valid, input ev_code, output ev_ack);
endinterface

// File: rtl/press_classifier_window_timer.sv
// Burst window counter: clear, enable, and a strobe at WINDOW_CYCLES-1.
module window_timer #(
  parameter int unsigned WINDOW_CYCLES = 25000000,
  parameter int unsigned CNT_W         = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign timeout = (count == LAST);

endmodule

// File: rtl/press_classifier.sv
// Classifies bursts of debounced presses as single/double(/triple) events.
// Triple detection is built only when PRESS_CLASSIFIER_TRIPLE_EN is defined.
module press_classifier
  import press_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 25000000,
  parameter int unsigned CNT_W         = 25,
  parameter int unsigned EVCNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               press_pulse,
  press_classifier_if.master ev,
  output logic               busy,
  output logic               ovf,
  output logic [EVCNT_W-1:0] ev_count
);

  state_t   state, state_nx;
  logic     tmr_clr, tmr_en, tmr_to;
  logic     cls_valid;
  ev_code_t cls_code;

  window_timer #(
    .WINDOW_CYCLES(WINDOW_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .timeout(tmr_to)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // The timer is held clear in IDLE so every burst starts counting from zero;
  // a press always takes priority over a same-cycle timeout.
  always_comb begin
    state_nx  = state;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    cls_valid = 1'b0;
    cls_code  = EV_NONE;
    unique case (state)
      IDLE: begin
        tmr_clr = 1'b1;
        if (press_pulse) state_nx = ARMED1;
      end
      ARMED1: begin
        tmr_en = 1'b1;
        if (press_pulse) begin
`ifdef PRESS_CLASSIFIER_TRIPLE_EN
          tmr_clr  = 1'b1;
          state_nx = ARMED2;
`else
          cls_valid = 1'b1;
          cls_code  = EV_DOUBLE;
          state_nx  = IDLE;
`endif
        end else if (tmr_to) begin
          cls_valid = 1'b1;
          cls_code  = EV_SINGLE;
          state_nx  = IDLE;
        end
      end
`ifdef PRESS_CLASSIFIER_TRIPLE_EN
      ARMED2: begin
        tmr_en = 1'b1;
        if (press_pulse) begin
          cls_valid = 1'b1;
          cls_code  = EV_TRIPLE;
          state_nx  = IDLE;
        end else if (tmr_to) begin
          cls_valid = 1'b1;
          cls_code  = EV_DOUBLE;
          state_nx  = IDLE;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // A new event may replace one being acked in the same cycle (no bubble);
  // otherwise an unacked event blocks it and the loss is flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev.ev_valid <= 1'b0;
      ev.ev_code  <= EV_NONE;
      ovf         <= 1'b0;
      ev_count    <= '0;
    end else if (cls_valid) begin
      if (!ev.ev_valid || ev.ev_ack) begin
        ev.ev_valid <= 1'b1;
        ev.ev_code  <= cls_code;
        ev_count    <= ev_count + EVCNT_W'(1);
      end else begin
        ovf <= 1'b1;
      end
    end else if (ev.ev_valid && ev.ev_ack) begin
      ev.ev_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_press_classifier.sv
// Scoreboard bench for press_classifier with WINDOW_CYCLES=10; follows
// PRESS_CLASSIFIER_TRIPLE_EN for its expected codes and timings.
module tb_press_classifier;
  import press_pkg::*;

`ifdef PRESS_CLASSIFIER_TRIPLE_EN
  localparam bit TRIPLE = 1'b1;
`else
  localparam bit TRIPLE = 1'b0;
`endif

  typedef struct {
    ev_code_t code;
    int       cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       press_pulse;
  logic       busy;
  logic       ovf;
  logic [7:0] ev_count;

  press_classifier_if ev_if();

  press_classifier #(
    .WINDOW_CYCLES(10),
    .CNT_W        (4),
    .EVCNT_W      (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .press_pulse(press_pulse),
    .ev         (ev_if.master),
    .busy       (busy),
    .ovf        (ovf),
    .ev_count   (ev_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  int         ack_lo, ack_hi;
  int         ackc, vs;
  int         presses[$];
  exp_t       sb_q[$];
  logic [7:0] last_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_ev(input ev_code_t code, input int c);
    exp_t e;
    e.code = code;
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  // One clock: drive this cycle's stimulus, advance, then score any newly loaded event.
  task automatic step();
    bit   p;
    exp_t e;
    p = 1'b0;
    foreach (presses[i]) if (presses[i] == cyc) p = 1'b1;
    press_pulse  = p;
    ev_if.ev_ack = (cyc >= ack_lo && cyc <= ack_hi);
    @(posedge clk);
    cyc++;
    #1;
    press_pulse = 1'b0;
    if (ev_count != last_cnt) begin
      if (sb_q.size() == 0) begin
        check_val("sb_spurious", 32'(ev_count), 32'(last_cnt));
      end else begin
        e = sb_q.pop_front();
        check_val("sb_code", 32'(ev_if.ev_code), 32'(e.code));
        check_val("sb_cycle", cyc, e.cyc);
        check_val("sb_count", 32'(ev_count), 32'(8'(last_cnt + 8'd1)));
      end
      last_cnt = ev_count;
    end
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    press_pulse  = 1'b0;
    ev_if.ev_ack = 1'b0;
    presses.delete();
    ack_lo = 1;
    ack_hi = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    cyc      = 0;
    last_cnt = 8'd0;
  endtask

  task automatic end_scn(input string tag);
    check_val({tag, "_sb_empty"}, sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    rst_n        = 1'b0;
    press_pulse  = 1'b0;
    ev_if.ev_ack = 1'b0;
    last_cnt     = 8'd0;

    // Single press, never acked
    do_reset();
    check_val("rst_valid", ev_if.ev_valid, 0);
    check_val("rst_code", ev_if.ev_code, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ovf", ovf, 0);
    check_val("rst_count", ev_count, 0);
    presses = '{5};
    expect_ev(EV_SINGLE, 16);
    while (cyc < 20) begin
      step();
      if (cyc >= 4 && cyc <= 18) begin
        check_val("s1_busy", busy, (cyc >= 6 && cyc <= 15));
        check_val("s1_valid", ev_if.ev_valid, (cyc >= 16));
      end
    end
    check_val("s1_code", ev_if.ev_code, EV_SINGLE);
    check_val("s1_count", ev_count, 1);
    end_scn("s1");

    // Two presses inside the window
    do_reset();
    vs = TRIPLE ? 20 : 10;
    presses = '{5, 9};
    expect_ev(EV_DOUBLE, vs);
    while (cyc < 24) begin
      step();
      if (cyc >= 4) begin
        check_val("s2_busy", busy, (cyc >= 6 && cyc < vs));
        check_val("s2_valid", ev_if.ev_valid, (cyc >= vs));
      end
    end
    check_val("s2_code", ev_if.ev_code, EV_DOUBLE);
    end_scn("s2");

    // Second press exactly on the last window cycle still counts
    do_reset();
    presses = '{5, 15};
    expect_ev(EV_DOUBLE, TRIPLE ? 26 : 16);
    while (cyc < 30) begin
      step();
      if (cyc == 16) begin
        check_val("s3a_busy16", busy, TRIPLE);
        check_val("s3a_valid16", ev_if.ev_valid, !TRIPLE);
      end
    end
    end_scn("s3a");

    // Press one cycle too late: single, then a fresh burst
    do_reset();
    presses = '{5, 16};
    ack_lo = 0;
    ack_hi = 1000;
    expect_ev(EV_SINGLE, 16);
    expect_ev(EV_SINGLE, 27);
    while (cyc < 30) begin
      step();
      if (cyc == 16) check_val("s3b_busy16", busy, 0);
      if (cyc == 17) check_val("s3b_busy17", busy, 1);
    end
    check_val("s3b_count", ev_count, 2);
    check_val("s3b_ovf", ovf, 0);
    end_scn("s3b");

    // Four presses: triple plus a new burst, or two doubles
    do_reset();
    presses = '{5, 9, 12, 14};
    ack_lo = 0;
    ack_hi = 1000;
    if (TRIPLE) begin
      expect_ev(EV_TRIPLE, 13);
      expect_ev(EV_SINGLE, 25);
    end else begin
      expect_ev(EV_DOUBLE, 10);
      expect_ev(EV_DOUBLE, 15);
    end
    while (cyc < 30) step();
    check_val("s4_count", ev_count, 2);
    check_val("s4_ovf", ovf, 0);
    end_scn("s4");

    // Two singles, no ack: second is dropped
    do_reset();
    presses = '{5, 20};
    expect_ev(EV_SINGLE, 16);
    while (cyc < 34) begin
      step();
      if (cyc == 30) check_val("s5_ovf30", ovf, 0);
      if (cyc == 31) check_val("s5_ovf31", ovf, 1);
    end
    check_val("s5_valid", ev_if.ev_valid, 1);
    check_val("s5_code", ev_if.ev_code, EV_SINGLE);
    check_val("s5_count", ev_count, 1);
    check_val("s5_ovf", ovf, 1);
    end_scn("s5");

    // Two singles, ack held high throughout
    do_reset();
    presses = '{5, 20};
    ack_lo = 0;
    ack_hi = 1000;
    expect_ev(EV_SINGLE, 16);
    expect_ev(EV_SINGLE, 31);
    while (cyc < 34) begin
      step();
      if (cyc == 17) begin
        check_val("s6_valid17", ev_if.ev_valid, 0);
        check_val("s6_code17", ev_if.ev_code, EV_SINGLE);
      end
    end
    check_val("s6_count", ev_count, 2);
    check_val("s6_ovf", ovf, 0);
    check_val("s6_valid", ev_if.ev_valid, 0);
    end_scn("s6");

    // Ack coincides with the next classification: replaced with no bubble
    do_reset();
    ackc = TRIPLE ? 34 : 24;
    presses = '{5, 20, 24};
    ack_lo = ackc;
    ack_hi = ackc;
    expect_ev(EV_SINGLE, 16);
    expect_ev(EV_DOUBLE, ackc + 1);
    while (cyc < 40) begin
      step();
      if (cyc == ackc) begin
        check_val("s7_valid_hold", ev_if.ev_valid, 1);
        check_val("s7_code_hold", ev_if.ev_code, EV_SINGLE);
      end
      if (cyc == ackc + 1) begin
        check_val("s7_valid_b2b", ev_if.ev_valid, 1);
        check_val("s7_ovf_b2b", ovf, 0);
      end
    end
    check_val("s7_valid_end", ev_if.ev_valid, 1);
    check_val("s7_count", ev_count, 2);
    end_scn("s7");

    // Asynchronous reset in the middle of a burst
    do_reset();
    presses = '{5, 20};
    expect_ev(EV_SINGLE, 16);
    while (cyc < 23) step();
    end_scn("s8_pre");
    #3;
    rst_n = 1'b0;
    #1;
    check_val("s8_valid", ev_if.ev_valid, 0);
    check_val("s8_code", ev_if.ev_code, 0);
    check_val("s8_busy", busy, 0);
    check_val("s8_ovf", ovf, 0);
    check_val("s8_count", ev_count, 0);
    last_cnt = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    presses.delete();
    while (cyc < 25) step();
    check_val("s8_count_after", ev_count, 0);
    check_val("s8_valid_after", ev_if.ev_valid, 0);
    check_val("s8_busy_after", busy, 0);
    end_scn("s8");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
